pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 16-bit 5-stage pipeline.
- Drives the write-enable and flush (bubble) inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves these events:
  - load-use hazards;
  - taken-branch squash;
  - multi-cycle instruction/data memory waits;
  - halt drain.
- Includes a stall watchdog; sits beside the pipeline registers in the CPU top level.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 11 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared CPU constants for the hazard sequencer (FSM encoding, register index width, watchdog default).
package pipe_hazard_ctrl_pkg;
    localparam int REG_W = 4;
    localparam int STALL_TIMEOUT_DEF = 255;
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DSTALL = 2'b01,
        ISTALL = 2'b10,
        HALTED = 2'b11
    } state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the load in EX and the source registers of the instruction in ID.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             idex_memRead,
    input  logic [REG_W-1:0] idex_writeReg,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_useRs,
    input  logic             ifid_useRt,
    output logic             hazard
);
    // r0 is hardwired zero, so a load targeting it never produces a dependency
    assign hazard = idex_memRead && idex_writeReg != '0 &&
                    ((ifid_useRs && ifid_rs == idex_writeReg) || (ifid_useRt && ifid_rt == idex_writeReg));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipe with memory-stall watchdog.
// Define PIPE_HAZARD_PERF_EN to add the stall_cycles / bubble_cnt performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memRead,
    input  logic [REG_W-1:0] idex_writeReg,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_useRs,
    input  logic             ifid_useRt,
    input  logic             branch_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
`ifdef PIPE_HAZARD_PERF_EN
    output logic             wdog_err,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      bubble_cnt
`else
    output logic             wdog_err
`endif
);
    state_t state, state_nx, eff;
    logic [CNT_W-1:0] cnt;
    logic err_q, lu_q, hz, lu_act, stall, hit, run, ist;

    hazard_detect u_hd (
        .idex_memRead (idex_memRead),
        .idex_writeReg(idex_writeReg),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_useRs   (ifid_useRs),
        .ifid_useRt   (ifid_useRt),
        .hazard       (hz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            err_q <= 1'b0;
            lu_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (eff == RUN) ? '0 : (stall && cnt != '1) ? cnt + CNT_W'(1) : cnt;
            err_q <= err_q | hit;
            lu_q  <= lu_act;
        end
    end

    // eff is the mode in force this cycle, so stalls and their release act with zero latency
    always_comb begin
        eff      = (state == HALTED || (state == RUN && memwb_halt)) ? HALTED :
                   dmem_busy ? DSTALL : imem_busy ? ISTALL : RUN;
        state_nx = hit ? HALTED : eff;
    end

    assign stall  = eff == DSTALL || eff == ISTALL;
    assign hit    = stall && cnt == CNT_W'(STALL_TIMEOUT - 1);
    assign run    = eff == RUN;
    assign ist    = eff == ISTALL;
    // the cycle after a bubble EX holds that bubble, so the same pair cannot stall twice
    assign lu_act = run && hz && !lu_q;

    always_comb begin
        pc_en      = run && !lu_act;
        ifid_en    = (run && !lu_act) || ist;
        ifid_flush = ist || (run && !lu_act && branch_taken);
        idex_en    = run || ist;
        idex_flush = lu_act;
        exmem_en   = run || ist;
        memwb_en   = run || ist;
        halted     = eff == HALTED;
        wdog_err   = err_q || hit;
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic bubble;
    assign bubble = lu_act || (run && branch_taken);
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            bubble_cnt   <= '0;
        end else begin
            if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
            if (bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of the hazard sequencer (default timeout and a timeout-4 watchdog instance).
module tb_pipe_hazard_ctrl;
    logic clk, rst;
    logic idex_memRead, ifid_useRs, ifid_useRt, branch_taken, imem_busy, dmem_busy, memwb_halt;
    logic [3:0] idex_writeReg, ifid_rs, ifid_rt;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted, wdog_err;
    logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_en, w_memwb_en, w_halted, w_wdog_err;
    logic [8:0] outs, outs_wd;
    int n_chk, n_fail;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] sc, bc, w_sc, w_bc;
`endif

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted, wdog_err}
    localparam logic [8:0] DEF  = 9'b110101100;
    localparam logic [8:0] LU   = 9'b000111100;
    localparam logic [8:0] BR   = 9'b111101100;
    localparam logic [8:0] FRZ  = 9'b000000000;
    localparam logic [8:0] FRZW = 9'b000000001;
    localparam logic [8:0] IST  = 9'b011101100;
    localparam logic [8:0] HLT  = 9'b000000010;
    localparam logic [8:0] HLTW = 9'b000000011;

    assign outs    = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted, wdog_err};
    assign outs_wd = {w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_en, w_memwb_en, w_halted, w_wdog_err};

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .idex_memRead(idex_memRead), .idex_writeReg(idex_writeReg),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_useRs(ifid_useRs), .ifid_useRt(ifid_useRt),
        .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy), .memwb_halt(memwb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .halted(halted),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_cycles(sc), .bubble_cnt(bc),
`endif
        .wdog_err(wdog_err)
    );

    pipe_hazard_ctrl #(.STALL_TIMEOUT(4)) dut_wd (
        .clk(clk), .rst(rst), .idex_memRead(idex_memRead), .idex_writeReg(idex_writeReg),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_useRs(ifid_useRs), .ifid_useRt(ifid_useRt),
        .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy), .memwb_halt(memwb_halt),
        .pc_en(w_pc_en), .ifid_en(w_ifid_en), .ifid_flush(w_ifid_flush), .idex_en(w_idex_en), .idex_flush(w_idex_flush),
        .exmem_en(w_exmem_en), .memwb_en(w_memwb_en), .halted(w_halted),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_cycles(w_sc), .bubble_cnt(w_bc),
`endif
        .wdog_err(w_wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task clear_in;
        idex_memRead = 0; idex_writeReg = 0; ifid_rs = 0; ifid_rt = 0; ifid_useRs = 0; ifid_useRt = 0;
        branch_taken = 0; imem_busy = 0; dmem_busy = 0; memwb_halt = 0;
    endtask

    task idle;
        clear_in();
        tick();
    endtask

    task test_reset;
        rst = 1;
        tick(); tick();
        rst = 0;
        #2;
        n_chk++; if (outs !== DEF) begin n_fail++; $display("FAIL reset outs=%b exp=%b", outs, DEF); end
        n_chk++; if (outs_wd !== DEF) begin n_fail++; $display("FAIL reset_wd outs=%b exp=%b", outs_wd, DEF); end
        tick();
    endtask

    task test_load_use;
        idex_memRead = 1; idex_writeReg = 3; ifid_rs = 3; ifid_useRs = 1;
        #2;
        n_chk++; if (outs !== LU) begin n_fail++; $display("FAIL lu_c1 outs=%b exp=%b", outs, LU); end
        tick(); #2;
        n_chk++; if (outs !== DEF) begin n_fail++; $display("FAIL lu_c2_one_bubble outs=%b exp=%b", outs, DEF); end
        tick(); clear_in(); #2;
        n_chk++; if (outs !== DEF) begin n_fail++; $display("FAIL lu_after outs=%b exp=%b", outs, DEF); end
        tick();
        idex_memRead = 1; idex_writeReg = 5; ifid_rt = 5; ifid_useRt = 1;
        #2;
        n_chk++; if (outs !== LU) begin n_fail++; $display("FAIL lu_rt outs=%b exp=%b", outs, LU); end
        idle();
    endtask

    task test_load_use_r0;
        idex_memRead = 1; idex_writeReg = 0; ifid_rs = 0; ifid_useRs = 1;
        #2;
        n_chk++; if (outs !== DEF) begin n_fail++; $display("FAIL lu_r0 outs=%b exp=%b", outs, DEF); end
        tick();
        idex_writeReg = 3; ifid_rs = 3; ifid_useRs = 0;
        #2;
        n_chk++; if (outs !== DEF) begin n_fail++; $display("FAIL lu_no_use outs=%b exp=%b", outs, DEF); end
        tick();
        idex_memRead = 0; ifid_useRs = 1;
        #2;
        n_chk++; if (outs !== DEF) begin n_fail++; $display("FAIL lu_no_load outs=%b exp=%b", outs, DEF); end
        idle();
    endtask

    task test_branch;
        branch_taken = 1;
        #2;
        n_chk++; if (outs !== BR) begin n_fail++; $display("FAIL br outs=%b exp=%b", outs, BR); end
        tick(); branch_taken = 0; #2;
        n_chk++; if (outs !== DEF) begin n_fail++; $display("FAIL br_after outs=%b exp=%b", outs, DEF); end
        tick();
        branch_taken = 1; idex_memRead = 1; idex_writeReg = 3; ifid_rs = 3; ifid_useRs = 1;
        #2;
        n_chk++; if (outs !== LU) begin n_fail++; $display("FAIL br_lu_c1 outs=%b exp=%b", outs, LU); end
        tick(); #2;
        n_chk++; if (outs !== BR) begin n_fail++; $display("FAIL br_lu_c2 outs=%b exp=%b", outs, BR); end
        idle();
    endtask

    task test_dmiss_imiss;
        logic [8:0] exp [6];
        exp = '{FRZ, FRZ, FRZ, IST, IST, DEF};
        for (int i = 0; i < 6; i++) begin
            dmem_busy = (i < 3);
            imem_busy = (i < 5);
            #2;
            n_chk++; if (outs !== exp[i]) begin n_fail++; $display("FAIL dmiss_imiss_c%0d outs=%b exp=%b", i, outs, exp[i]); end
            tick();
        end
        idle();
    endtask

    task test_watchdog;
        logic [8:0] exp [5];
        exp = '{FRZ, FRZ, FRZ, FRZW, HLTW};
        rst = 1;
        tick();
        rst = 0; dmem_busy = 1;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_chk++; if (outs_wd !== exp[i]) begin n_fail++; $display("FAIL wdog_c%0d outs=%b exp=%b", i, outs_wd, exp[i]); end
            n_chk++; if (outs !== FRZ) begin n_fail++; $display("FAIL wdog_main_c%0d outs=%b exp=%b", i, outs, FRZ); end
            tick();
        end
        dmem_busy = 0;
        #2;
        n_chk++; if (outs_wd !== HLTW) begin n_fail++; $display("FAIL wdog_sticky outs=%b exp=%b", outs_wd, HLTW); end
        n_chk++; if (outs !== DEF) begin n_fail++; $display("FAIL wdog_main_release outs=%b exp=%b", outs, DEF); end
        idle();
    endtask

    task test_halt_reset;
        rst = 1;
        tick();
        rst = 0; memwb_halt = 1;
        tick(); #2;
        n_chk++; if (outs !== HLT) begin n_fail++; $display("FAIL halt outs=%b exp=%b", outs, HLT); end
        tick(); memwb_halt = 0; branch_taken = 1; imem_busy = 1; #2;
        n_chk++; if (outs !== HLT) begin n_fail++; $display("FAIL halt_hold outs=%b exp=%b", outs, HLT); end
        tick();
        rst = 1;
        tick();
        rst = 0; clear_in(); #2;
        n_chk++; if (outs !== DEF) begin n_fail++; $display("FAIL post_rst outs=%b exp=%b", outs, DEF); end
        n_chk++; if (outs_wd !== DEF) begin n_fail++; $display("FAIL post_rst_wd outs=%b exp=%b", outs_wd, DEF); end
`ifdef PIPE_HAZARD_PERF_EN
        n_chk++; if (sc !== 16'd0 || bc !== 16'd0 || w_sc !== 16'd0 || w_bc !== 16'd0) begin
            n_fail++; $display("FAIL perf_rst sc=%0d bc=%0d exp=0", sc, bc);
        end
`endif
        idle();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        clear_in();
        test_reset();
        test_load_use();
        test_load_use_r0();
        test_branch();
        test_dmiss_imiss();
        test_watchdog();
        test_halt_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
